fma9_dot_sequencer: RTL and testbench

Sequencing controller for the 9-term FMA dot-product datapath (nine a*b products aligned and summed with addend c per pass). It runs dot products longer than 9 terms by streaming 9-pair operand beats into the datapath and feeding each pass result back as the next pass's c operand. The job, beat and result interfaces use valid/ready handshakes. The controller owns the accumulator register and covers datapath hazard, timeout and abort handling.

---
 rtl/fma9_dot_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_fma9_dot_sequencer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fma9_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fma9_dot_sequencer
// Purpose  : Sequencing controller for the 9-term FMA dot-product datapath.
//            Streams 9-pair operand beats into the datapath one pass at a
//            time and feeds each pass result back as the next addend, so a
//            dot product of job_len beats is produced. It owns the
//            accumulator and handles datapath hazard, timeout and abort.
// Ports    : clk, rst_n (async active-low)
//            job_*   : job handshake (length in beats, initial addend)
//            beat_*  : operand beat handshake (LANES a/b words, lane 0 LSBs)
//            abort   : synchronous job cancel
//            fma_*   : registered operands/strobe to the datapath, result back
//            res_*   : final result handshake with timeout error flag
//            spurious_err : sticky, result strobe seen outside WAIT/DRAIN
//            busy    : controller not idle
// Revision : 1.0 - initial release
// ============================================================================
module fma9_dot_sequencer #(
  parameter int WIDTH     = 32,
  parameter int LANES     = 9,
  parameter int LEN_WIDTH = 8,
  parameter int PIPE_LAT  = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   job_valid,
  output logic                   job_ready,
  input  logic [LEN_WIDTH-1:0]   job_len,
  input  logic [WIDTH-1:0]       job_c_init,
  input  logic                   beat_valid,
  output logic                   beat_ready,
  input  logic [LANES*WIDTH-1:0] beat_a,
  input  logic [LANES*WIDTH-1:0] beat_b,
  input  logic                   abort,
  output logic                   fma_issue,
  output logic [LANES*WIDTH-1:0] fma_a,
  output logic [LANES*WIDTH-1:0] fma_b,
  output logic [WIDTH-1:0]       fma_c,
  input  logic                   fma_res_valid,
  input  logic [WIDTH-1:0]       fma_res,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_err,
  output logic                   spurious_err,
  output logic                   busy
);

  // The watchdog limit is TIMEOUT-1, but never shorter than the nominal
  // datapath latency, otherwise every healthy pass would be declared lost.
  localparam int C_WD_LIMIT = (TIMEOUT - 1 > PIPE_LAT + 1) ? (TIMEOUT - 1) : (PIPE_LAT + 1);
  localparam int C_WD_W     = $clog2(C_WD_LIMIT + 1);
  localparam logic [C_WD_W-1:0]    C_WD_MAX = C_WD_W'(C_WD_LIMIT);
  localparam logic [C_WD_W-1:0]    C_WD_ONE = C_WD_W'(1);
  localparam logic [LEN_WIDTH-1:0] C_LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic [LEN_WIDTH-1:0]   remaining_q, remaining_d;
  logic [C_WD_W-1:0]      wd_q, wd_d;
  logic [C_WD_W-1:0]      wd_inc;
  logic [LANES*WIDTH-1:0] fma_a_q, fma_a_d;
  logic [LANES*WIDTH-1:0] fma_b_q, fma_b_d;
  logic [WIDTH-1:0]       fma_c_q, fma_c_d;
  logic                   fma_issue_q, fma_issue_d;
  logic                   res_err_q, res_err_d;
  logic                   spurious_q, spurious_d;
  logic                   job_ready_q, job_ready_d;
  logic                   beat_ready_q, beat_ready_d;
  logic                   res_valid_q, res_valid_d;
  logic [WIDTH-1:0]       res_data_q, res_data_d;
  logic                   busy_q, busy_d;

  // Saturating so the counter can never wrap past the limit.
  assign wd_inc = (wd_q == C_WD_MAX) ? wd_q : (wd_q + C_WD_ONE);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    wd_d        = wd_q;
    fma_a_d     = fma_a_q;
    fma_b_d     = fma_b_q;
    fma_c_d     = fma_c_q;
    fma_issue_d = 1'b0;
    res_err_d   = res_err_q;
    spurious_d  = spurious_q;

    case (state_q)
      S_IDLE: begin
        // abort in IDLE also blocks a simultaneous job offer
        if (job_valid && !abort) begin
          acc_d       = job_c_init;
          remaining_d = job_len;
          spurious_d  = 1'b0;
          res_err_d   = 1'b0;
          state_d     = (job_len == '0) ? S_DONE : S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (beat_valid) begin
          fma_a_d     = beat_a;
          fma_b_d     = beat_b;
          fma_c_d     = acc_q;
          fma_issue_d = 1'b1;
          remaining_d = remaining_q - C_LEN_ONE;
          wd_d        = '0;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (abort) begin
          // the pass in flight must still be absorbed before a new job
          state_d = S_DRAIN;
          wd_d    = wd_inc;
        end else if (fma_res_valid) begin
          acc_d     = fma_res;
          res_err_d = 1'b0;
          state_d   = (remaining_q == '0) ? S_DONE : S_ISSUE;
        end else if (wd_q == C_WD_MAX) begin
          res_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          wd_d = wd_inc;
        end
      end

      S_DONE: begin
        if (abort || res_ready) begin
          res_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      S_DRAIN: begin
        // late result of the cancelled job is discarded, acc untouched
        if (fma_res_valid || (wd_q == C_WD_MAX)) begin
          state_d = S_IDLE;
        end else begin
          wd_d = wd_inc;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A result strobe with no pass outstanding is flagged; set wins over
    // the clear on job accept so a coincident strobe is not lost.
    if (fma_res_valid && (state_q == S_IDLE || state_q == S_ISSUE || state_q == S_DONE)) begin
      spurious_d = 1'b1;
    end

    // Status outputs are registered from the next state.
    job_ready_d  = (state_d == S_IDLE);
    beat_ready_d = (state_d == S_ISSUE);
    res_valid_d  = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    res_data_d   = (state_d == S_DONE) ? acc_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      remaining_q  <= '0;
      wd_q         <= '0;
      fma_a_q      <= '0;
      fma_b_q      <= '0;
      fma_c_q      <= '0;
      fma_issue_q  <= 1'b0;
      res_err_q    <= 1'b0;
      spurious_q   <= 1'b0;
      job_ready_q  <= 1'b1;
      beat_ready_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      remaining_q  <= remaining_d;
      wd_q         <= wd_d;
      fma_a_q      <= fma_a_d;
      fma_b_q      <= fma_b_d;
      fma_c_q      <= fma_c_d;
      fma_issue_q  <= fma_issue_d;
      res_err_q    <= res_err_d;
      spurious_q   <= spurious_d;
      job_ready_q  <= job_ready_d;
      beat_ready_q <= beat_ready_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      busy_q       <= busy_d;
    end
  end

  assign job_ready    = job_ready_q;
  assign beat_ready   = beat_ready_q;
  assign fma_issue    = fma_issue_q;
  assign fma_a        = fma_a_q;
  assign fma_b        = fma_b_q;
  assign fma_c        = fma_c_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_err      = res_err_q;
  assign spurious_err = spurious_q;
  assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fma9_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fma9_dot_sequencer
// Purpose  : Scoreboard bench for fma9_dot_sequencer. Directed jobs push the
//            expected datapath issues and final results into queues; a
//            monitor pops and compares whenever the DUT issues a pass or
//            hands over a result. A behavioural datapath answers each issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fma9_dot_sequencer;

  localparam int W  = 32;
  localparam int L  = 9;
  localparam int LW = 8;
  localparam int TO = 16;
  localparam int DP_LAT = 4;

  logic            clk;
  logic            rst_n;
  logic            job_valid;
  logic            job_ready;
  logic [LW-1:0]   job_len;
  logic [W-1:0]    job_c_init;
  logic            beat_valid;
  logic            beat_ready;
  logic [L*W-1:0]  beat_a;
  logic [L*W-1:0]  beat_b;
  logic            abort;
  logic            fma_issue;
  logic [L*W-1:0]  fma_a;
  logic [L*W-1:0]  fma_b;
  logic [W-1:0]    fma_c;
  logic            res_valid;
  logic            res_ready;
  logic [W-1:0]    res_data;
  logic            res_err;
  logic            spurious_err;
  logic            busy;

  logic            dp_vld, spur_vld;
  logic [W-1:0]    dp_data, spur_data;
  int              dp_mode;

  fma9_dot_sequencer #(
    .WIDTH(W), .LANES(L), .LEN_WIDTH(LW), .PIPE_LAT(DP_LAT), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_c_init(job_c_init),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_a(beat_a), .beat_b(beat_b),
    .abort(abort),
    .fma_issue(fma_issue), .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c),
    .fma_res_valid(dp_vld | spur_vld), .fma_res(dp_vld ? dp_data : spur_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .spurious_err(spurious_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [W-1:0] c;
    logic [W-1:0] a0;
    logic [W-1:0] b8;
  } iss_t;

  iss_t          iq[$];
  logic [W:0]    rq[$];          // {res_err, res_data}
  int            icyc[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_issue = 0;
  int            issue_cyc = 0;
  logic [W-1:0]  beat_base;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  iss_t        m_e;
  logic [W:0]  m_r;
  always @(negedge clk) begin
    if (rst_n && fma_issue) begin
      n_issue++;
      issue_cyc = cyc;
      icyc.push_back(cyc);
      if (iq.size() == 0) begin
        chk("unexpected_issue", 64'd1, 64'd0);
      end else begin
        m_e = iq.pop_front();
        chk("fma_c", 64'(fma_c), 64'(m_e.c));
        chk("fma_a_lane0", 64'(fma_a[0 +: W]), 64'(m_e.a0));
        chk("fma_b_lane8", 64'(fma_b[8*W +: W]), 64'(m_e.b8));
      end
    end
    if (rst_n && res_valid && res_ready) begin
      if (rq.size() == 0) begin
        chk("unexpected_result", 64'd1, 64'd0);
      end else begin
        m_r = rq.pop_front();
        chk("res_data", 64'(res_data), 64'(m_r[W-1:0]));
        chk("res_err", 64'(res_err), 64'(m_r[W]));
      end
    end
  end

  // ---------------- datapath model ----------------
  // mode 1: returns c + 1.0 for the small set of floats used here
  // mode 2: returns the integer c + 1 (long-job counting)
  function automatic logic [W-1:0] dp_fn(input logic [W-1:0] c);
    if (dp_mode == 2) return c + 32'd1;
    case (c)
      32'h0000_0000: return 32'h3F80_0000;
      32'h3F80_0000: return 32'h4000_0000;
      32'h4000_0000: return 32'h4040_0000;
      32'h4040_0000: return 32'h4080_0000;
      default:       return c;
    endcase
  endfunction

  logic [W-1:0] dp_c;
  initial begin
    dp_vld  = 1'b0;
    dp_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && fma_issue && dp_mode != 0) begin
        dp_c = fma_c;
        repeat (DP_LAT) @(posedge clk);
        #1 dp_vld = 1'b1;
        dp_data = dp_fn(dp_c);
        @(posedge clk);
        #1 dp_vld = 1'b0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beats(input logic [W-1:0] base);
    beat_base = base;
    for (int k = 0; k < L; k++) begin
      beat_a[k*W +: W] = base + W'(k);
      beat_b[k*W +: W] = ~base + W'(k);
    end
  endtask

  task automatic push_iss(input logic [W-1:0] c);
    iss_t e;
    e.c  = c;
    e.a0 = beat_base;
    e.b8 = ~beat_base + W'(8);
    iq.push_back(e);
  endtask

  task automatic start_job(input logic [LW-1:0] len, input logic [W-1:0] c);
    int n;
    n = 0;
    while (!job_ready && n < 50) begin
      step();
      n++;
    end
    if (!job_ready) chk("job_ready_timeout", 64'd0, 64'd1);
    job_valid  = 1'b1;
    job_len    = len;
    job_c_init = c;
    step();
    job_valid  = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!job_ready && n < budget) begin
      step();
      n++;
    end
    if (!job_ready) chk(name, 64'd0, 64'd1);
  endtask

  task automatic wait_issue(input string name, input int budget);
    int n;
    n = 0;
    while (!fma_issue && n < budget) begin
      step();
      n++;
    end
    if (!fma_issue) chk(name, 64'd0, 64'd1);
  endtask

  // ---------------- stimulus ----------------
  int n0, n, t_res, seen;
  initial begin
    rst_n = 1'b0; job_valid = 1'b0; job_len = '0; job_c_init = '0;
    beat_valid = 1'b0; beat_a = '0; beat_b = '0; abort = 1'b0;
    res_ready = 1'b1; spur_vld = 1'b0; spur_data = '0; dp_mode = 0;
    set_beats(32'hA000_0000);
    step(); step();
    chk("reset_flags", 64'({job_ready, beat_ready, fma_issue, res_valid, res_err, spurious_err, busy}),
        64'b1000000);
    chk("reset_res_data", 64'(res_data), 64'd0);
    rst_n = 1'b1;
    step();

    // job_len = 0: result is the initial addend, no pass issued
    n0 = n_issue;
    rq.push_back({1'b0, 32'h3F80_0000});
    start_job(8'd0, 32'h3F80_0000);
    n = 0;
    while (!res_valid && n < 5) begin step(); n++; end
    chk("len0_latency_ok", 64'(n <= 1), 64'd1);
    wait_idle("len0_idle_timeout", 10);
    chk("len0_issues", 64'(n_issue - n0), 64'd0);

    // three-beat job, c + 1.0 datapath at latency 4
    dp_mode = 1;
    set_beats(32'hA100_0000);
    beat_valid = 1'b1;
    icyc.delete();
    push_iss(32'h0000_0000);
    push_iss(32'h3F80_0000);
    push_iss(32'h4000_0000);
    rq.push_back({1'b0, 32'h4040_0000});
    start_job(8'd3, 32'h0000_0000);
    wait_idle("len3_idle_timeout", 60);
    chk("len3_issue_count", 64'(icyc.size()), 64'd3);
    if (icyc.size() == 3) begin
      chk("len3_gap01", 64'(icyc[1] - icyc[0]), 64'd6);
      chk("len3_gap12", 64'(icyc[2] - icyc[1]), 64'd6);
    end
    chk("len3_spurious", 64'(spurious_err), 64'd0);

    // datapath silent: timeout after TIMEOUT cycles in WAIT
    dp_mode = 0;
    set_beats(32'hA200_0000);
    n0 = n_issue;
    push_iss(32'h40A0_0000);
    rq.push_back({1'b1, 32'h40A0_0000});
    start_job(8'd2, 32'h40A0_0000);
    n = 0;
    while (!res_valid && n < 40) begin step(); n++; end
    t_res = cyc;
    chk("timeout_res_valid", 64'(res_valid), 64'd1);
    chk("timeout_wait_cycles", 64'(t_res - issue_cyc), 64'(TO));
    wait_idle("timeout_idle_timeout", 10);
    chk("timeout_issues", 64'(n_issue - n0), 64'd1);

    // abort one cycle after the first issue; late result swallowed by DRAIN
    dp_mode = 1;
    set_beats(32'hA300_0000);
    push_iss(32'h3F80_0000);
    start_job(8'd2, 32'h3F80_0000);
    wait_issue("abort_issue_timeout", 10);
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    push_iss(32'h4040_0000);
    rq.push_back({1'b0, 32'h4080_0000});
    job_valid = 1'b1; job_len = 8'd1; job_c_init = 32'h4040_0000;
    n = 0;
    while (!job_ready && n < 30) begin step(); n++; end
    chk("drain_hold_cycles", 64'(n), 64'd3);
    step();
    job_valid = 1'b0;
    chk("drain_spurious", 64'(spurious_err), 64'd0);
    wait_idle("drain_job_idle_timeout", 40);
    chk("drain_job_spurious", 64'(spurious_err), 64'd0);

    // spurious strobe in IDLE, clear on accept, stable DONE under backpressure
    res_ready = 1'b0;
    spur_data = 32'h1234_5678;
    spur_vld = 1'b1;
    step();
    spur_vld = 1'b0;
    chk("spur_idle_set", 64'({spurious_err, busy, res_valid}), 64'b100);
    rq.push_back({1'b0, 32'h40E0_0000});
    start_job(8'd0, 32'h40E0_0000);
    chk("spur_clear_on_accept", 64'(spurious_err), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("done_hold_valid", 64'(res_valid), 64'd1);
      chk("done_hold_data", 64'(res_data), 64'h40E0_0000);
      spur_vld = (i == 1);
      step();
    end
    spur_vld = 1'b0;
    chk("spur_done_set", 64'(spurious_err), 64'd1);
    res_ready = 1'b1;
    wait_idle("backpressure_idle_timeout", 10);

    // abort in IDLE blocks a coincident job
    abort = 1'b1; job_valid = 1'b1; job_len = 8'd0; job_c_init = 32'h5555_0000;
    step();
    abort = 1'b0; job_valid = 1'b0;
    chk("idle_abort_ignored", 64'({job_ready, busy, res_valid}), 64'b100);

    // abort in ISSUE with a coincident beat: no pass emitted
    beat_valid = 1'b0;
    n0 = n_issue;
    start_job(8'd5, 32'h3F80_0000);
    chk("issue_beat_ready", 64'(beat_ready), 64'd1);
    abort = 1'b1; beat_valid = 1'b1;
    step();
    abort = 1'b0; beat_valid = 1'b0;
    chk("issue_abort_flags", 64'({job_ready, beat_ready, fma_issue, busy}), 64'b1000);
    chk("issue_abort_issues", 64'(n_issue - n0), 64'd0);

    // abort in DONE: result withdrawn
    res_ready = 1'b0;
    start_job(8'd0, 32'h4100_0000);
    chk("done_before_abort", 64'(res_valid), 64'd1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("done_abort_flags", 64'({job_ready, res_valid, busy}), 64'b100);
    res_ready = 1'b1;

    // maximum length job: 255 passes, remaining must not wrap
    dp_mode = 2;
    set_beats(32'hA400_0000);
    beat_valid = 1'b1;
    n0 = n_issue;
    for (int i = 0; i < 255; i++) push_iss(W'(i));
    rq.push_back({1'b0, 32'h0000_00FF});
    start_job(8'hFF, 32'h0000_0000);
    wait_idle("len255_idle_timeout", 2000);
    chk("len255_issues", 64'(n_issue - n0), 64'd255);

    // asynchronous reset while a pass is in flight
    dp_mode = 0;
    set_beats(32'hA500_0000);
    push_iss(32'h3F80_0000);
    start_job(8'd2, 32'h3F80_0000);
    wait_issue("rst_issue_timeout", 10);
    step(); step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_wait_flags", 64'({job_ready, fma_issue, res_valid, busy}), 64'b1000);
    chk("rst_wait_res_data", 64'(res_data), 64'd0);
    chk("rst_wait_fma_c", 64'(fma_c), 64'd0);
    beat_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < TO + 4; i++) begin
      step();
      if (res_valid || busy) seen = 1;
    end
    chk("rst_no_activity", 64'(seen), 64'd0);

    chk("issue_queue_empty", 64'(iq.size()), 64'd0);
    chk("result_queue_empty", 64'(rq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
